// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular arbiter sharing one UART transmitter among NREQ byte streams.
// A grant lasts until the owner's last byte drains or the owner idles past GAP_TIMEOUT cycles.
module uart_tx_arbiter #(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned ID_W        = 2,
  parameter int unsigned GAP_TIMEOUT = 256
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic              wr_en,
  output logic [7:0]        wr_data,
  input  logic              tx_busy,
  output logic              grant_active,
  output logic [ID_W-1:0]   grant_id,
  output logic              abort
);

  localparam int unsigned GapW = $clog2(GAP_TIMEOUT) + 1;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StGuard,
    StWaitTx,
    StHold
  } state_e;

  state_e          state_q;
  logic            wr_en_q;
  logic [7:0]      wr_data_q;
  logic            grant_active_q;
  logic [ID_W-1:0] grant_id_q;
  logic            abort_q;
  logic [ID_W-1:0] rr_q;
  logic [GapW-1:0] gap_q;
  logic            last_q;

  logic              found;
  logic [ID_W-1:0]   winner;
  int unsigned       idx;
  logic [NREQ-1:0]   valid_sh;
  logic [NREQ-1:0]   last_sh;
  logic [8*NREQ-1:0] data_sh;
  logic [ID_W-1:0]   sel_id;
  logic [7:0]        sel_byte;
  logic              sel_last;
  logic              owner_valid;
  logic [ID_W-1:0]   next_rr;
  logic              idle_take;

  // First valid requester at or above the RR pointer, wrapping modulo NREQ.
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    idx      = 0;
    valid_sh = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = 32'(rr_q) + i;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end
      valid_sh = req_valid >> idx;
      if (!found && valid_sh[0]) begin
        found  = 1'b1;
        winner = ID_W'(idx);
      end
    end
  end

  // One shared byte/last selector: the RR winner in idle, the owner otherwise.
  always_comb begin
    sel_id      = (state_q == StIdle) ? winner : grant_id_q;
    data_sh     = req_data >> {sel_id, 3'b000};
    last_sh     = req_last >> sel_id;
    sel_byte    = data_sh[7:0];
    sel_last    = last_sh[0];
    owner_valid = |(req_valid & ({{(NREQ-1){1'b0}}, 1'b1} << grant_id_q));
    next_rr     = (grant_id_q == ID_W'(NREQ - 1)) ? '0 : grant_id_q + 1'b1;
    idle_take   = found && !tx_busy;
  end

  // Ready is combinational and gated by reset so no byte is consumed while held in reset.
  always_comb begin
    req_ready = '0;
    if (rstb) begin
      case (state_q)
        StIdle: if (idle_take) req_ready = {{(NREQ-1){1'b0}}, 1'b1} << winner;
        StHold: if (owner_valid) req_ready = {{(NREQ-1){1'b0}}, 1'b1} << grant_id_q;
        default: req_ready = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q        <= StIdle;
      wr_en_q        <= 1'b0;
      wr_data_q      <= '0;
      grant_active_q <= 1'b0;
      grant_id_q     <= '0;
      abort_q        <= 1'b0;
      rr_q           <= '0;
      gap_q          <= '0;
      last_q         <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      abort_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (idle_take) begin
            wr_en_q        <= 1'b1;
            wr_data_q      <= sel_byte;
            last_q         <= sel_last;
            grant_id_q     <= winner;
            grant_active_q <= 1'b1;
            state_q        <= StIssue;
          end
        end
        StIssue: state_q <= StGuard;
        // uart_top asserts tx_busy one cycle after wr_en, so this cycle is blind.
        StGuard: state_q <= StWaitTx;
        StWaitTx: begin
          if (!tx_busy) begin
            if (last_q) begin
              state_q        <= StIdle;
              grant_active_q <= 1'b0;
              rr_q           <= next_rr;
            end else begin
              state_q <= StHold;
              gap_q   <= '0;
            end
          end
        end
        StHold: begin
          if (owner_valid) begin
            wr_en_q   <= 1'b1;
            wr_data_q <= sel_byte;
            last_q    <= sel_last;
            state_q   <= StIssue;
          end else if (gap_q == GapW'(GAP_TIMEOUT - 1)) begin
            state_q        <= StIdle;
            abort_q        <= 1'b1;
            grant_active_q <= 1'b0;
            rr_q           <= next_rr;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign wr_en        = wr_en_q;
  assign wr_data      = wr_data_q;
  assign grant_active = grant_active_q;
  assign grant_id     = grant_id_q;
  assign abort        = abort_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a simple busy-window model of uart_top.
module tb_uart_tx_arbiter;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned ID_W  = 2;
  localparam int unsigned GAP   = 16;
  localparam int unsigned FRAME = 10;

  logic              clk = 1'b0;
  logic              rstb;
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic              wr_en;
  logic [7:0]        wr_data;
  logic              tx_busy;
  logic              grant_active;
  logic [ID_W-1:0]   grant_id;
  logic              abort;

  int          total = 0;
  int          bad   = 0;
  int          viol  = 0;
  int unsigned busy_cnt = 0;
  logic [9:0]  log_q[$];

  uart_tx_arbiter #(
    .NREQ       (NREQ),
    .ID_W       (ID_W),
    .GAP_TIMEOUT(GAP)
  ) dut (
    .clk         (clk),
    .rstb        (rstb),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .tx_busy     (tx_busy),
    .grant_active(grant_active),
    .grant_id    (grant_id),
    .abort       (abort)
  );

  always #10 clk = ~clk;

  // Transmitter model: busy for FRAME cycles starting the cycle after wr_en.
  assign tx_busy = (busy_cnt != 0);
  always @(posedge clk) begin
    if (wr_en) busy_cnt <= FRAME;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    if (wr_en) log_q.push_back({grant_id, wr_data});
    viol <= viol + int'(!$onehot0(req_ready)) + int'(wr_en && tx_busy) + int'(wr_en && |req_ready);
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [7:0] d, input logic l);
    req_valid[i]      = v;
    req_data[8*i +: 8] = d;
    req_last[i]       = l;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_idle(input string tag);
    logic ok;
    ok = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      #1;
      if (!grant_active && !tx_busy && !wr_en) begin
        ok = 1'b1;
        break;
      end
    end
    check(tag, 32'(ok), 32'd1);
  endtask

  logic [7:0] t3_bytes[3] = '{8'h11, 8'h22, 8'h33};
  logic [9:0] e;
  logic       acc1, acc2, r2_early, hold_bad, early;
  int         k, n;

  initial begin
    rstb      = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    set_req(0, 1'b1, 8'hA5, 1'b1);

    // Reset state, with a request pending that must not be accepted yet
    step(); #1;
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_gact", 32'(grant_active), 32'd0);
    check("rst_gid", 32'(grant_id), 32'd0);
    check("rst_abort", 32'(abort), 32'd0);

    // T1 single byte
    step();
    rstb = 1'b1;
    #1;
    check("t1_ready", 32'(req_ready), 32'h1);
    step();
    req_valid = '0;
    #1;
    check("t1_wr_en", 32'(wr_en), 32'd1);
    check("t1_wr_data", 32'(wr_data), 32'hA5);
    check("t1_gact", 32'(grant_active), 32'd1);
    check("t1_ready_off", 32'(req_ready), 32'd0);
    wait_idle("t1_idle");
    check("t1_count", 32'(log_q.size()), 32'd1);
    if (log_q.size() > 0) check("t1_log", 32'(log_q[0]), 32'h0A5);

    // T2 round-robin from a fresh pointer
    step();
    rstb = 1'b0;
    step();
    rstb = 1'b1;
    log_q.delete();
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 8'h10 + 8'(i), 1'b1);
    for (int c = 0; c < 600 && log_q.size() < 8; c++) step();
    req_valid = '0;
    wait_idle("t2_idle");
    check("t2_count", 32'(log_q.size()), 32'd8);
    for (int i = 0; i < 8 && i < log_q.size(); i++) begin
      e[9:8] = 2'(i % 4);
      e[7:0] = 8'h10 + 8'(i % 4);
      check($sformatf("t2_log%0d", i), 32'(log_q[i]), 32'(e));
    end

    // T3 packet lock: pointer is 0, req1 owns until its last byte
    step();
    log_q.delete();
    k = 0;
    r2_early = 1'b0;
    set_req(1, 1'b1, t3_bytes[0], 1'b0);
    set_req(2, 1'b1, 8'h44, 1'b1);
    for (int c = 0; c < 800 && log_q.size() < 4; c++) begin
      #1;
      if (k < 3 && req_ready[2]) r2_early = 1'b1;
      acc1 = req_valid[1] && req_ready[1];
      acc2 = req_valid[2] && req_ready[2];
      step();
      if (acc1) begin
        k++;
        if (k == 3) req_valid[1] = 1'b0;
        else set_req(1, 1'b1, t3_bytes[k], k == 2);
      end
      if (acc2) req_valid[2] = 1'b0;
    end
    req_valid = '0;
    wait_idle("t3_idle");
    check("t3_r2_locked_out", 32'(r2_early), 32'd0);
    check("t3_count", 32'(log_q.size()), 32'd4);
    if (log_q.size() == 4) begin
      check("t3_log0", 32'(log_q[0]), 32'h111);
      check("t3_log1", 32'(log_q[1]), 32'h122);
      check("t3_log2", 32'(log_q[2]), 32'h133);
      check("t3_log3", 32'(log_q[3]), 32'h244);
    end

    // T4 timeout: pointer is 3, req3 stalls mid-packet, req0 waits
    step();
    set_req(3, 1'b1, 8'h55, 1'b0);
    set_req(0, 1'b1, 8'h66, 1'b1);
    #1;
    check("t4_ready3", 32'(req_ready), 32'h8);
    step();
    req_valid[3] = 1'b0;
    #1;
    check("t4_wr55", 32'({wr_en, wr_data}), 32'h155);
    for (int c = 0; c < 100; c++) begin
      step(); #1;
      if (!tx_busy) break;
    end
    hold_bad = 1'b0;
    n = 0;
    step(); #1;
    for (int c = 0; c < 40; c++) begin
      if (abort) break;
      if (req_ready != 0) hold_bad = 1'b1;
      n++;
      step(); #1;
    end
    check("t4_abort_delay", 32'(n), 32'd16);
    check("t4_hold_ready", 32'(hold_bad), 32'd0);
    check("t4_gact_abort", 32'(grant_active), 32'd0);
    check("t4_ready0", 32'(req_ready), 32'h1);
    step();
    req_valid[0] = 1'b0;
    #1;
    check("t4_abort_pulse", 32'(abort), 32'd0);
    check("t4_wr66", 32'({wr_en, grant_id, wr_data}), 32'h066 | 32'h400);
    wait_idle("t4_idle");

    // T5 reset during WAIT_TX: pointer is 1, req2 wins
    step();
    set_req(2, 1'b1, 8'h77, 1'b1);
    #1;
    check("t5_ready2", 32'(req_ready), 32'h4);
    step();
    req_valid[2] = 1'b0;
    #1;
    check("t5_wr77", 32'({wr_en, wr_data}), 32'h177);
    step();
    step();
    step();
    rstb = 1'b0;
    set_req(0, 1'b1, 8'h80, 1'b1);
    set_req(1, 1'b1, 8'h81, 1'b1);
    #1;
    check("t5_ready_in_rst", 32'(req_ready), 32'd0);
    step(); #1;
    check("t5_outs_zero",
          32'({wr_en, wr_data, grant_active, grant_id, abort, req_ready}), 32'd0);
    step();
    step();
    rstb = 1'b1;
    #1;
    check("t5_busy_blocks", 32'({tx_busy, req_ready}), 32'h10);
    early = 1'b0;
    for (int c = 0; c < 100 && tx_busy; c++) begin
      if (wr_en) early = 1'b1;
      step(); #1;
    end
    check("t5_ready0", 32'(req_ready), 32'h1);
    step();
    req_valid = '0;
    #1;
    check("t5_no_early_wr", 32'(early), 32'd0);
    check("t5_wr80", 32'({wr_en, grant_id, wr_data}), 32'h480);
    wait_idle("t5_idle");

    check("invariants", 32'(viol), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
